// File: rtl/nm_link_pkg.sv
// Shared definitions for the NM serial link receiver: timing, frame layout,
// FSM states, frame type encodings and a saturating counter helper.
package nm_link_pkg;

  localparam int unsigned CLK_DIV      = 10;
  localparam int unsigned FRAME_TYPE_W = 2;
  localparam int unsigned PAYLOAD_W    = 16;
  localparam int unsigned FRAME_BITS   = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    ADC    = 2'd0,
    REG_RD = 2'd1,
    ACK    = 2'd2,
    ERR    = 2'd3
  } frame_type_e;

  typedef struct packed {
    logic [FRAME_TYPE_W-1:0] ftype;
    logic [PAYLOAD_W-1:0]    payload;
  } rx_frame_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nm_link_rx_fifo.sv
// Frame buffer for the link receiver; extra pointer MSB separates full from empty.
// A push on a full buffer succeeds only when a pop happens on the same edge.
module nm_link_rx_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: reads are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nm_link_rx.sv
// NM serial link receiver: bit-strobe divider, frame deserializer with even
// parity check, frame FIFO, and saturating error/overflow counters.
module nm_link_rx
  import nm_link_pkg::*;
#(
  parameter int unsigned DEBUG_BUS_SIZE = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      run,
  input  logic                      n2c_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FRAME_TYPE_W-1:0]   out_type,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [7:0]                par_err_cnt,
  output logic [7:0]                ovf_cnt,
  input  logic                      cnt_clr,
  output logic [DEBUG_BUS_SIZE-1:0] debug
);

  localparam int unsigned DIV_W      = $clog2(CLK_DIV);
  localparam int unsigned SHIFT_BITS = FRAME_BITS - 2;
  localparam int unsigned CNT_W      = 5;

  logic [DIV_W-1:0]      div;
  logic                  bit_stb;
  rx_state_e             state;
  logic [SHIFT_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_sample_c;
  logic                  par_ok_c;
  logic                  push_c;
  logic                  par_err_c;
  logic                  pop_c;
  logic                  ovf_c;
  logic                  fifo_full;
  rx_frame_t             head;

  assign bit_stb      = (div == '0);
  assign par_sample_c = run && bit_stb && (state == PARITY);
  assign par_ok_c     = ~(^{shreg, n2c_data});
  assign push_c       = par_sample_c && par_ok_c;
  assign par_err_c    = par_sample_c && !par_ok_c;
  assign pop_c        = out_valid && out_ready;
  assign ovf_c        = push_c && fifo_full && !pop_c;

  // Free-running bit-period divider; strobe when it reads zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div <= '0;
    end else if (div == DIV_W'(CLK_DIV - 1)) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Deserializer: start bit, 18 data bits MSB first, then the parity sample.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (!run) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bit_stb) begin
      case (state)
        IDLE: begin
          if (n2c_data) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[SHIFT_BITS-2:0], n2c_data};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(SHIFT_BITS - 1)) state <= PARITY;
        end
        PARITY:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  nm_link_rx_fifo #(
    .WIDTH ($bits(rx_frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push_c),
    .wdata (shreg),
    .pop   (pop_c),
    .rdata (head),
    .valid (out_valid),
    .full  (fifo_full)
  );

  assign out_type    = head.ftype;
  assign out_payload = head.payload;

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      par_err_cnt <= '0;
      ovf_cnt     <= '0;
    end else if (cnt_clr) begin
      par_err_cnt <= '0;
      ovf_cnt     <= '0;
    end else begin
      if (par_err_c) par_err_cnt <= sat_inc8(par_err_cnt);
      if (ovf_c)     ovf_cnt     <= sat_inc8(ovf_cnt);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      debug <= '0;
    end else begin
      debug <= DEBUG_BUS_SIZE'({(state != IDLE), bit_stb, fifo_full, out_valid});
    end
  end

endmodule

// File: tb/tb_nm_link_rx.sv
// Directed and randomized frame stimulus for nm_link_rx, checked against a
// frame-level model of delivery order, buffer occupancy and error counters.
`timescale 1ns/1ps
module tb_nm_link_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        run = 1'b0;
  logic        n2c_data = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        out_valid;
  logic [1:0]  out_type;
  logic [15:0] out_payload;
  logic [7:0]  par_err_cnt;
  logic [7:0]  ovf_cnt;
  logic [3:0]  debug;

  int checks = 0;
  int failures = 0;

  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int m_par = 0;
  int m_ovf = 0;
  int m_occ = 0;

  logic        snap_v0, snap_v1;
  logic [1:0]  snap_t;
  logic [15:0] snap_p;

  nm_link_rx #(.DEBUG_BUS_SIZE(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .run         (run),
    .n2c_data    (n2c_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_type    (out_type),
    .out_payload (out_payload),
    .par_err_cnt (par_err_cnt),
    .ovf_cnt     (ovf_cnt),
    .cnt_clr     (cnt_clr),
    .debug       (debug)
  );

  always #25 clk = ~clk;

  always @(negedge clk) begin
    if (rstb && out_valid && out_ready) got_q.push_back({out_type, out_payload});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // One bit period: the first edge after this call is the sampling strobe.
  task automatic send_bit(input logic b);
    n2c_data = b;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] t, input logic [15:0] p, input bit bad,
                            input bit pop_at_par, input bit clr_at_par);
    logic [17:0] d;
    bit ready_at_edge;
    bit pop_now;
    d = {t, p};
    send_bit(1'b1);
    for (int i = 17; i >= 0; i--) send_bit(d[i]);
    n2c_data = (^d) ^ bad;
    if (pop_at_par) out_ready = 1'b1;
    if (clr_at_par) cnt_clr = 1'b1;
    ready_at_edge = out_ready;
    @(posedge clk); #1;
    snap_v0 = out_valid;
    snap_t  = out_type;
    snap_p  = out_payload;
    if (pop_at_par) out_ready = 1'b0;
    cnt_clr  = 1'b0;
    n2c_data = 1'b0;
    @(posedge clk); #1;
    snap_v1 = out_valid;
    repeat (8) @(posedge clk);
    #1;
    pop_now = ready_at_edge && (m_occ > 0);
    if (bad) m_par = sat(m_par);
    else if (m_occ == DEPTH && !pop_now) m_ovf = sat(m_ovf);
    else begin
      exp_q.push_back(d);
      m_occ++;
    end
    if (pop_now) m_occ--;
    if (clr_at_par) begin
      m_par = 0;
      m_ovf = 0;
    end
    if (out_ready) m_occ = 0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    send_bit(1'b0);
    out_ready = 1'b0;
    m_occ = 0;
  endtask

  task automatic chk_delivered(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_item"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] rp;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_type", 32'(out_type), 0);
    chk("rst_payload", 32'(out_payload), 0);
    chk("rst_par_cnt", 32'(par_err_cnt), 0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
    chk("rst_debug", 32'(debug), 0);

    @(negedge clk);
    rstb = 1'b1;
    run = 1'b1;
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);

    // Single good ADC frame
    send_frame(2'd0, 16'hA5C3, 1'b0, 1'b0, 1'b0);
    chk("adc_valid_lat1", 32'(snap_v0), 1);
    chk("adc_type", 32'(snap_t), 0);
    chk("adc_payload", 32'(snap_p), 32'h0000A5C3);
    chk("adc_valid_pulse", 32'(snap_v1), 0);
    chk_delivered("adc");

    // Parity error frame
    send_frame(2'd1, 16'h0001, 1'b1, 1'b0, 1'b0);
    chk("perr_no_valid", 32'(snap_v0), 0);
    chk("perr_cnt", 32'(par_err_cnt), 32'(m_par));
    chk("perr_cnt_one", 32'(par_err_cnt), 1);
    chk_delivered("perr");

    // Overflow with consumer stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(2'($urandom_range(3)), 16'(k), 1'b0, 1'b0, 1'b0);
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("ovf_cnt_one", 32'(ovf_cnt), 1);
    chk("ovf_valid", 32'(out_valid), 1);
    chk("ovf_head_stable", 32'(out_payload), 1);
    chk("ovf_full", 32'(debug[1]), 1);
    drain();
    chk_delivered("ovf_order");

    // Full buffer with pop and push on the same edge
    for (int k = 0; k < 4; k++) send_frame(2'd2, 16'h0010 + 16'(k), 1'b0, 1'b0, 1'b0);
    send_frame(2'd3, 16'h0014, 1'b0, 1'b1, 1'b0);
    chk("simul_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("simul_full", 32'(debug[1]), 32'(m_occ == DEPTH));
    chk("simul_head", 32'(out_payload), 32'h11);
    drain();
    chk_delivered("simul_order");

    // Abort a frame by dropping run mid-frame
    out_ready = 1'b1;
    send_bit(1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(1)));
    run = 1'b0;
    send_bit(1'b0);
    run = 1'b1;
    send_bit(1'b0);
    send_frame(2'd1, 16'h1234, 1'b0, 1'b0, 1'b0);
    chk_delivered("abort");
    chk("abort_par_cnt", 32'(par_err_cnt), 32'(m_par));
    chk("abort_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));

    // Random frames with occasional parity errors and idle gaps
    for (int n = 0; n < 24; n++) begin
      rp = 16'($urandom);
      send_frame(2'($urandom_range(3)), rp, ($urandom_range(3) == 0), 1'b0, 1'b0);
      for (int g = 0; g < int'($urandom_range(2)); g++) send_bit(1'b0);
    end
    chk_delivered("rand");
    chk("rand_par_cnt", 32'(par_err_cnt), 32'(m_par));
    chk("rand_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("rand_idle_valid", 32'(out_valid), 0);

    // Counter clear, saturation, and clear winning over an increment
    cnt_clr = 1'b1;
    send_bit(1'b0);
    cnt_clr = 1'b0;
    m_par = 0;
    m_ovf = 0;
    chk("clr_par_cnt", 32'(par_err_cnt), 0);
    chk("clr_ovf_cnt", 32'(ovf_cnt), 0);
    for (int n = 0; n < 256; n++) send_frame(2'($urandom_range(3)), 16'($urandom), 1'b1, 1'b0, 1'b0);
    chk("sat_par_cnt", 32'(par_err_cnt), 32'(m_par));
    chk("sat_par_cnt_255", 32'(par_err_cnt), 255);
    send_frame(2'd0, 16'h5555, 1'b1, 1'b0, 1'b1);
    chk("clr_wins_par", 32'(par_err_cnt), 32'(m_par));
    chk("clr_wins_zero", 32'(par_err_cnt), 0);
    chk_delivered("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
